race_state_encoder: RTL and testbench
=====================================

# race_state_encoder

Top-level race sequencer. It turns debounced button pulses, the link-ready flag and lap-sensor pulses into the 3-bit game state consumed by the audio encoder and the display. It also owns the 3-2-1 countdown timing, lap counting and the race timer. All outputs are registered and change only on the rising edge of `clk`.

## Interface
- `CLK_HZ`, 100_000_000, clock cycles per second; must be divisible by 100.
- `SYNC_TIMEOUT_S`, 5, seconds allowed in SYNCING before abort.
- `MAX_LAPS`, 9, upper bound for `target_laps`; must be in 1..15.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `btn_start` in 1: one-cycle pulse; start / confirm.
- `btn_back` in 1: one-cycle pulse; abort / back.
- `btn_pause` in 1: one-cycle pulse; pause / resume toggle.
- `btn_up` in 1: one-cycle pulse; increment laps in SETTING.
- `btn_down` in 1: one-cycle pulse; decrement laps in SETTING.
- `peer_ready` in 1: level; remote unit is ready.
- `lap_pulse` in 1: one-cycle pulse; lap line crossed.
- `state` out 3: IDLE=0, SETTING=1, SYNCING=2, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6; value 7 is never driven.
- `cd_digit` out 2: countdown digit 3/2/1; 0 outside COUNTDOWN.
- `target_laps` out 4: configured lap count.
- `lap_cnt` out 4: completed laps.
- `race_cs` out 16: race time in centiseconds; saturates at 16'hFFFF.
- `sync_fail` out 1: one-cycle pulse on SYNCING timeout.

## Operation
- Reset values: `state`=IDLE, `cd_digit`=0, `target_laps`=3, `lap_cnt`=0, `race_cs`=0, `sync_fail`=0. All internal counters are cleared.
- Button priority within one cycle: `btn_back` > `btn_start` > `btn_pause` > `btn_up` > `btn_down`. Only the highest-priority asserted button acts. Buttons with no meaning in the current state are ignored.
- IDLE: `btn_start` → SETTING. On entry to IDLE, `lap_cnt`, `race_cs` and the sub-counters clear; `target_laps` is retained.
- SETTING:
  - `btn_up`/`btn_down` change `target_laps` by ±1, clamped to 1..MAX_LAPS with no wrap.
  - `btn_start` → SYNCING.
  - `btn_back` → IDLE.
- SYNCING:
  - `peer_ready`=1 → COUNTDOWN.
  - After CLK_HZ*SYNC_TIMEOUT_S cycles in state, → SETTING with `sync_fail`=1 for exactly that transition cycle.
  - `btn_back` → SETTING; `sync_fail` stays 0.
  - If `peer_ready` and timeout occur in the same cycle, `peer_ready` wins.
- COUNTDOWN:
  - The second counter starts at 0 on entry.
  - `cd_digit` = 3 for cycles [0, CLK_HZ), 2 for [CLK_HZ, 2·CLK_HZ), 1 for [2·CLK_HZ, 3·CLK_HZ).
  - → RACING after 3·CLK_HZ cycles.
  - `btn_back` → IDLE. `btn_pause` is ignored.
- RACING:
  - A centisecond prescaler counts to CLK_HZ/100−1. `race_cs` increments on each wrap and saturates.
  - `lap_pulse` increments `lap_cnt`. If the new value equals `target_laps`, → FINISH in the same cycle.
  - `btn_pause` → PAUSE.
  - Lap completion to FINISH beats `btn_pause` and `btn_back` when they coincide.
  - `btn_back` → IDLE.
- PAUSE:
  - The prescaler and `race_cs` freeze and `lap_pulse` is ignored.
  - `btn_pause` → RACING; the prescaler resumes from its frozen value.
  - `btn_back` → IDLE.
- FINISH: `race_cs` and `lap_cnt` hold. `btn_start` or `btn_back` → IDLE.

## Timing
- Every transition takes effect on the clock edge where its condition is sampled high. `state` is valid the following cycle with zero extra latency.
- `cd_digit` is registered and aligned to `state`: the first cycle with `state`=COUNTDOWN shows `cd_digit`=3.
- The first cycle with `state`=RACING has `race_cs`=0. `race_cs`=1 appears CLK_HZ/100 cycles later.
- A `lap_pulse` in the cycle RACING is entered counts.
- `rst` low in any state forces the reset values on the next edge, overriding all other inputs.

## Configuration
- `RACE_SYNC_EN` defined: SYNCING behaves as described above.
- `RACE_SYNC_EN` undefined:
  - SETTING `btn_start` goes directly to COUNTDOWN. SYNCING (2) is never driven.
  - `peer_ready` is ignored and `sync_fail` is tied to 0.
  - The sync timeout counter is not synthesized.

## Test plan
All scenarios use CLK_HZ=1000 and SYNC_TIMEOUT_S=2.
- Reset low → `state`=0, `target_laps`=3, `race_cs`=0; `btn_start`, `btn_up` ×10, `btn_start` → `target_laps`=9 (clamped), `state`=2.
- SYNCING with `peer_ready`=1 → COUNTDOWN; `cd_digit` reads 3, 2, 1 at cycles 0, 1000, 2000; `state`=4 at cycle 3000.
- SYNCING with `peer_ready`=0 for 2000 cycles → `sync_fail` pulses once, `state`=1.
- RACING for 500 cycles, `btn_pause`, wait 5000 cycles, `btn_pause`, run 500 cycles → `race_cs`=100.
- `target_laps`=2: two `lap_pulse`, the second coincident with `btn_pause` → `state`=6, `lap_cnt`=2, `race_cs` holds.
- Mid-COUNTDOWN, `rst` low for 1 cycle → `state`=0, `cd_digit`=0; the same test built without `RACE_SYNC_EN` shows SETTING→COUNTDOWN directly.

Source files
------------

// File: rtl/race_state_encoder.sv
// race_state_encoder: race sequencer producing game state, countdown digit, lap count and race timer.
// Define RACE_SYNC_EN to build the SYNCING handshake with the peer unit and its timeout counter.
module race_state_encoder #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SYNC_TIMEOUT_S = 5,
  parameter int MAX_LAPS       = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_back,
  input  logic        btn_pause,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        peer_ready,
  input  logic        lap_pulse,
  output logic [2:0]  state,
  output logic [1:0]  cd_digit,
  output logic [3:0]  target_laps,
  output logic [3:0]  lap_cnt,
  output logic [15:0] race_cs,
  output logic        sync_fail
);

  // state     | meaning
  // IDLE      | waiting for start; lap/time counters cleared
  // SETTING   | adjusting target_laps
  // SYNCING   | waiting for peer_ready (RACE_SYNC_EN only)
  // COUNTDOWN | 3-2-1 countdown, one second per digit
  // RACING    | race timer running, laps counted
  // PAUSE     | race timer frozen, laps ignored
  // FINISH    | results held until start/back
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETTING   = 3'd1;
  localparam logic [2:0] S_SYNCING   = 3'd2;
  localparam logic [2:0] S_COUNTDOWN = 3'd3;
  localparam logic [2:0] S_RACING    = 3'd4;
  localparam logic [2:0] S_PAUSE     = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  localparam int CS_DIV = CLK_HZ / 100;
  localparam int PW     = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;
  localparam int CW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LOAD = PW'(CS_DIV - 1);
  localparam logic [CW-1:0] CD_LOAD    = CW'(CLK_HZ - 1);
  localparam logic [3:0]    LAPS_MAX   = 4'(MAX_LAPS);

  logic [2:0]    state_nxt;
  logic [CW-1:0] cd_timer;
  logic [PW-1:0] presc;
  logic          cd_tc;
  logic          presc_tc;
  logic [3:0]    lap_next;
  logic          lap_done;

  logic act_back;
  logic act_start;
  logic act_pause;
  logic act_up;
  logic act_down;

  // Strict priority: only the highest asserted button is considered at all.
  assign act_back  = btn_back;
  assign act_start = btn_start & ~btn_back;
  assign act_pause = btn_pause & ~btn_back & ~btn_start;
  assign act_up    = btn_up & ~btn_back & ~btn_start & ~btn_pause;
  assign act_down  = btn_down & ~btn_back & ~btn_start & ~btn_pause & ~btn_up;

  assign cd_tc    = (cd_timer == '0);
  assign presc_tc = (presc == '0);
  assign lap_next = lap_cnt + 4'd1;
  assign lap_done = lap_pulse && (lap_next == target_laps);

`ifdef RACE_SYNC_EN
  localparam longint SYNC_CYC = longint'(CLK_HZ) * longint'(SYNC_TIMEOUT_S);
  localparam int     SW       = (SYNC_CYC > 1) ? $clog2(SYNC_CYC) : 1;
  localparam logic [SW-1:0] SYNC_LOAD = SW'(SYNC_CYC - 1);

  logic [SW-1:0] sync_timer;
  logic          sync_tc;
  logic          sync_to;
  logic          sync_fail_q;

  assign sync_tc = (sync_timer == '0);
`else
  logic unused_peer;
  assign unused_peer = peer_ready;
`endif

  always_comb begin
    state_nxt = state;
`ifdef RACE_SYNC_EN
    sync_to = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (act_start) state_nxt = S_SETTING;
      end
      S_SETTING: begin
        if (act_back) begin
          state_nxt = S_IDLE;
        end else if (act_start) begin
`ifdef RACE_SYNC_EN
          state_nxt = S_SYNCING;
`else
          state_nxt = S_COUNTDOWN;
`endif
        end
      end
      S_SYNCING: begin
`ifdef RACE_SYNC_EN
        // peer_ready is checked before the timeout so a late handshake still wins.
        if (act_back) begin
          state_nxt = S_SETTING;
        end else if (peer_ready) begin
          state_nxt = S_COUNTDOWN;
        end else if (sync_tc) begin
          state_nxt = S_SETTING;
          sync_to   = 1'b1;
        end
`else
        state_nxt = S_SETTING;
`endif
      end
      S_COUNTDOWN: begin
        if (act_back) begin
          state_nxt = S_IDLE;
        end else if (cd_tc && (cd_digit == 2'd1)) begin
          state_nxt = S_RACING;
        end
      end
      S_RACING: begin
        if (lap_done) begin
          state_nxt = S_FINISH;
        end else if (act_back) begin
          state_nxt = S_IDLE;
        end else if (act_pause) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (act_back) begin
          state_nxt = S_IDLE;
        end else if (act_pause) begin
          state_nxt = S_RACING;
        end
      end
      S_FINISH: begin
        if (act_back || act_start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cd_digit    <= 2'd0;
      cd_timer    <= '0;
      target_laps <= 4'd3;
      lap_cnt     <= 4'd0;
      race_cs     <= 16'd0;
      presc       <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_SETTING) begin
        if (act_up && (target_laps < LAPS_MAX)) begin
          target_laps <= target_laps + 4'd1;
        end else if (act_down && (target_laps > 4'd1)) begin
          target_laps <= target_laps - 4'd1;
        end
      end

      // Digit and its one-second down-counter are loaded on entry so the first
      // COUNTDOWN cycle already shows 3.
      if ((state_nxt == S_COUNTDOWN) && (state != S_COUNTDOWN)) begin
        cd_digit <= 2'd3;
        cd_timer <= CD_LOAD;
      end else if ((state == S_COUNTDOWN) && (state_nxt == S_COUNTDOWN)) begin
        if (cd_tc) begin
          cd_digit <= cd_digit - 2'd1;
          cd_timer <= CD_LOAD;
        end else begin
          cd_timer <= cd_timer - 1'b1;
        end
      end else begin
        cd_digit <= 2'd0;
        cd_timer <= '0;
      end

      if (state == S_COUNTDOWN) begin
        presc   <= PRESC_LOAD;
        race_cs <= 16'd0;
        lap_cnt <= 4'd0;
      end else if (state == S_RACING) begin
        if (presc_tc) begin
          presc <= PRESC_LOAD;
          if (race_cs != 16'hFFFF) race_cs <= race_cs + 16'd1;
        end else begin
          presc <= presc - 1'b1;
        end
        if (lap_pulse) lap_cnt <= lap_next;
      end

      if ((state_nxt == S_IDLE) && (state != S_IDLE)) begin
        presc   <= '0;
        race_cs <= 16'd0;
        lap_cnt <= 4'd0;
      end
    end
  end

`ifdef RACE_SYNC_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_timer  <= '0;
      sync_fail_q <= 1'b0;
    end else begin
      sync_fail_q <= sync_to;
      if (state != S_SYNCING) begin
        sync_timer <= SYNC_LOAD;
      end else if (!sync_tc) begin
        sync_timer <= sync_timer - 1'b1;
      end
    end
  end

  assign sync_fail = sync_fail_q;
`else
  assign sync_fail = 1'b0;
`endif

endmodule

// File: tb/tb_race_state_encoder.sv
// Self-checking bench for race_state_encoder (CLK_HZ=1000, SYNC_TIMEOUT_S=2).
// Expectations follow RACE_SYNC_EN the same way the design build does.
module tb_race_state_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_back = 1'b0;
  logic        btn_pause = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        peer_ready = 1'b0;
  logic        lap_pulse = 1'b0;
  logic [2:0]  state;
  logic [1:0]  cd_digit;
  logic [3:0]  target_laps;
  logic [3:0]  lap_cnt;
  logic [15:0] race_cs;
  logic        sync_fail;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  race_state_encoder #(.CLK_HZ(1000), .SYNC_TIMEOUT_S(2), .MAX_LAPS(9)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_back(btn_back),
    .btn_pause(btn_pause), .btn_up(btn_up), .btn_down(btn_down),
    .peer_ready(peer_ready), .lap_pulse(lap_pulse), .state(state),
    .cd_digit(cd_digit), .target_laps(target_laps), .lap_cnt(lap_cnt),
    .race_cs(race_cs), .sync_fail(sync_fail)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // b: 0 start, 1 back, 2 pause, 3 up, 4 down
  task automatic press(input int b);
    case (b)
      0: btn_start = 1'b1;
      1: btn_back  = 1'b1;
      2: btn_pause = 1'b1;
      3: btn_up    = 1'b1;
      default: btn_down = 1'b1;
    endcase
    tick(1);
    btn_start = 1'b0; btn_back = 1'b0; btn_pause = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  // Leaves the bench in the first COUNTDOWN cycle.
  task automatic enter_countdown(input int downs);
    do_reset();
    press(0);
    repeat (downs) press(4);
    press(0);
`ifdef RACE_SYNC_EN
    peer_ready = 1'b1;
    tick(1);
    peer_ready = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_start = 1'b1; lap_pulse = 1'b1;
    tick(2);
    btn_start = 1'b0; lap_pulse = 1'b0;
    exp_q.push_back('{"rst_state", 16'd0});
    exp_q.push_back('{"rst_cd_digit", 16'd0});
    exp_q.push_back('{"rst_target", 16'd3});
    exp_q.push_back('{"rst_lap_cnt", 16'd0});
    exp_q.push_back('{"rst_race_cs", 16'd0});
    exp_q.push_back('{"rst_sync_fail", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(cd_digit) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, cd_digit, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(target_laps) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, target_laps, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(lap_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, lap_cnt, e.val); end
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(sync_fail) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, sync_fail, e.val); end
    rst = 1'b1;
  endtask

  task automatic test_setting();
    do_reset();
    press(0);
    exp_q.push_back('{"set_enter", 16'd1});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    repeat (10) press(3);
    exp_q.push_back('{"up_clamp", 16'd9});
    e = exp_q.pop_front(); checks++;
    if (16'(target_laps) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, target_laps, e.val); end
    repeat (10) press(4);
    exp_q.push_back('{"down_clamp", 16'd1});
    e = exp_q.pop_front(); checks++;
    if (16'(target_laps) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, target_laps, e.val); end
    btn_up = 1'b1; btn_down = 1'b1;
    tick(1);
    btn_up = 1'b0; btn_down = 1'b0;
    exp_q.push_back('{"up_over_down", 16'd2});
    e = exp_q.pop_front(); checks++;
    if (16'(target_laps) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, target_laps, e.val); end
    btn_back = 1'b1; btn_up = 1'b1;
    tick(1);
    btn_back = 1'b0; btn_up = 1'b0;
    exp_q.push_back('{"back_to_idle", 16'd0});
    exp_q.push_back('{"idle_keeps_target", 16'd2});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(target_laps) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, target_laps, e.val); end
    press(0);
    repeat (10) press(3);
    press(0);
`ifdef RACE_SYNC_EN
    exp_q.push_back('{"setting_start", 16'd2});
`else
    exp_q.push_back('{"setting_start", 16'd3});
`endif
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
  endtask

  task automatic test_countdown();
    enter_countdown(0);
    exp_q.push_back('{"cd_state0", 16'd3});
    exp_q.push_back('{"cd_digit0", 16'd3});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(cd_digit) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, cd_digit, e.val); end
    press(2);
    tick(998);
    exp_q.push_back('{"cd_digit999", 16'd3});
    e = exp_q.pop_front(); checks++;
    if (16'(cd_digit) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, cd_digit, e.val); end
    tick(1);
    exp_q.push_back('{"cd_digit1000", 16'd2});
    e = exp_q.pop_front(); checks++;
    if (16'(cd_digit) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, cd_digit, e.val); end
    tick(1000);
    exp_q.push_back('{"cd_digit2000", 16'd1});
    e = exp_q.pop_front(); checks++;
    if (16'(cd_digit) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, cd_digit, e.val); end
    tick(999);
    exp_q.push_back('{"cd_state2999", 16'd3});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    tick(1);
    exp_q.push_back('{"race_state3000", 16'd4});
    exp_q.push_back('{"race_cd_digit", 16'd0});
    exp_q.push_back('{"race_cs_first", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(cd_digit) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, cd_digit, e.val); end
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
    tick(9);
    exp_q.push_back('{"race_cs_9", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
    tick(1);
    exp_q.push_back('{"race_cs_10", 16'd1});
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
  endtask

  task automatic test_sync();
`ifdef RACE_SYNC_EN
    do_reset();
    press(0);
    press(0);
    tick(1999);
    exp_q.push_back('{"sync_state1999", 16'd2});
    exp_q.push_back('{"sync_fail1999", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(sync_fail) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, sync_fail, e.val); end
    tick(1);
    exp_q.push_back('{"timeout_state", 16'd1});
    exp_q.push_back('{"timeout_fail", 16'd1});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(sync_fail) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, sync_fail, e.val); end
    tick(1);
    exp_q.push_back('{"fail_one_cycle", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (16'(sync_fail) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, sync_fail, e.val); end
    press(0);
    press(1);
    exp_q.push_back('{"sync_back_state", 16'd1});
    exp_q.push_back('{"sync_back_fail", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(sync_fail) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, sync_fail, e.val); end
    press(0);
    tick(1999);
    peer_ready = 1'b1;
    tick(1);
    peer_ready = 1'b0;
    exp_q.push_back('{"peer_beats_timeout", 16'd3});
    exp_q.push_back('{"peer_no_fail", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(sync_fail) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, sync_fail, e.val); end
`else
    int seen;
    seen = 0;
    do_reset();
    press(0);
    peer_ready = 1'b1;
    press(0);
    exp_q.push_back('{"direct_countdown", 16'd3});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    for (int i = 0; i < 2500; i++) begin
      peer_ready = i[3];
      tick(1);
      if (sync_fail !== 1'b0) seen++;
    end
    peer_ready = 1'b0;
    exp_q.push_back('{"sync_fail_tied", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (16'(seen) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, seen, e.val); end
`endif
  endtask

  task automatic test_pause();
    enter_countdown(0);
    tick(3000);
    tick(504);
    press(2);
    exp_q.push_back('{"pause_state", 16'd5});
    exp_q.push_back('{"pause_race_cs", 16'd50});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
    for (int i = 0; i < 5000; i++) begin
      lap_pulse = (i % 97 == 0);
      tick(1);
    end
    lap_pulse = 1'b0;
    exp_q.push_back('{"paused_race_cs", 16'd50});
    exp_q.push_back('{"paused_lap_cnt", 16'd0});
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(lap_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, lap_cnt, e.val); end
    press(2);
    exp_q.push_back('{"resume_state", 16'd4});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    tick(494);
    exp_q.push_back('{"resume_cs_999", 16'd99});
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
    tick(1);
    exp_q.push_back('{"resume_cs_1000", 16'd100});
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
  endtask

  task automatic test_finish();
    enter_countdown(1);
    tick(3000);
    lap_pulse = 1'b1;
    tick(1);
    lap_pulse = 1'b0;
    exp_q.push_back('{"lap_first_cycle", 16'd1});
    e = exp_q.pop_front(); checks++;
    if (16'(lap_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, lap_cnt, e.val); end
    tick(20);
    lap_pulse = 1'b1; btn_pause = 1'b1;
    tick(1);
    lap_pulse = 1'b0; btn_pause = 1'b0;
    exp_q.push_back('{"finish_state", 16'd6});
    exp_q.push_back('{"finish_lap_cnt", 16'd2});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(lap_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, lap_cnt, e.val); end
    tick(50);
    exp_q.push_back('{"finish_hold_cs", 16'd2});
    exp_q.push_back('{"finish_hold_state", 16'd6});
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    press(0);
    exp_q.push_back('{"finish_idle", 16'd0});
    exp_q.push_back('{"idle_clear_lap", 16'd0});
    exp_q.push_back('{"idle_clear_cs", 16'd0});
    exp_q.push_back('{"idle_keep_target", 16'd2});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(lap_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, lap_cnt, e.val); end
    e = exp_q.pop_front(); checks++;
    if (race_cs !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, race_cs, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(target_laps) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, target_laps, e.val); end
  endtask

  task automatic test_reset_mid_countdown();
    enter_countdown(2);
    tick(1500);
    rst = 1'b0; btn_start = 1'b1;
    tick(1);
    rst = 1'b1; btn_start = 1'b0;
    exp_q.push_back('{"midcd_rst_state", 16'd0});
    exp_q.push_back('{"midcd_rst_digit", 16'd0});
    exp_q.push_back('{"midcd_rst_target", 16'd3});
    e = exp_q.pop_front(); checks++;
    if (16'(state) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(cd_digit) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, cd_digit, e.val); end
    e = exp_q.pop_front(); checks++;
    if (16'(target_laps) !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, target_laps, e.val); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_setting();
    test_countdown();
    test_sync();
    test_pause();
    test_finish();
    test_reset_mid_countdown();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
